anneal_controller: RTL and testbench
====================================

# anneal_controller

Sequences one annealing run of a shorted-cell oscillator array: releases the array's active-low oscillator reset, waits a programmable settle time, then samples every oscillator output against oscillator 0 over a programmable window and resolves each spin by majority phase mismatch. Sits between the host/register interface and the array; its `osc_rstn` output drives the `rstn` input of every cell.

## Interface
Parameters:
- `N`, 4: number of oscillators/spins (≥2); `osc_in[0]` is the phase reference.
- `CNT_W`, 16: width of the cycle counts and of the per-spin mismatch counters.
- `SYNC_STAGES`, 2: flop stages in each `osc_in` synchronizer (≥2).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: cancel the run in progress, synchronous.
- `run_cycles` in CNT_W: settle length R, latched on accepted start; 0 is treated as 1.
- `sample_cycles` in CNT_W: sample window S, latched on accepted start; 0 is treated as 1.
- `osc_in` in N: raw oscillator outputs, asynchronous to `clk`.
- `osc_rstn` out 1: array reset, 0 = held in reset.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when `spins` has been updated.
- `spins` out N: resolved spin vector; bit 0 is always 0.

## Operation
- Each `osc_in[i]` passes through its own `SYNC_STAGES` synchronizer, giving `sync[i]`. Synchronizers are never bypassed and clear to 0 on reset.
- IDLE:
  - Outputs: `osc_rstn`=0, `busy`=0.
  - `start`=1 with `abort`=0 latches R and S, clears all mismatch counters and the cycle counter, and moves to RUN.
  - `start` together with `abort` stays in IDLE.
- RUN:
  - Outputs: `osc_rstn`=1, `busy`=1.
  - Counts R cycles, then moves to SAMPLE.
- SAMPLE:
  - Outputs: `osc_rstn`=1, `busy`=1.
  - On each of S cycles, for i in 1..N-1, `mcnt[i]` += `sync[i]` ^ `sync[0]`. Counters saturate at 2^CNT_W−1.
  - After S cycles, moves to RESOLVE.
- RESOLVE (one cycle):
  - Outputs: `osc_rstn`=0, `busy`=1.
  - Computes `spins[i]` = (2·`mcnt[i]` > S), using a CNT_W+1-bit compare. A tie resolves to 0.
  - Moves to IDLE. The new `spins` value and `done`=1 appear in the first IDLE cycle.
- `abort`=1 in RUN, SAMPLE or RESOLVE:
  - Next state is IDLE, with `osc_rstn`=0 and `busy`=0 from the next cycle.
  - `spins` is left unchanged and `done` is not asserted.
  - `abort` in IDLE has no effect.
- `start` while `busy`=1 is ignored. It is not queued.
- Changes to `run_cycles`/`sample_cycles` after an accepted start do not affect the run in progress.

## Timing
- Reset values: state IDLE, `osc_rstn`=0, `busy`=0, `done`=0, `spins`=0, all counters 0.
- `rst` asserted at any point, including mid-run, forces the reset values asynchronously; the array is re-held in reset immediately.
- All outputs are registered, with no combinational path from inputs to outputs.
- Start accepted at edge t:
  - `osc_rstn`=1 and `busy`=1 during cycles t+1 … t+R+S.
  - SAMPLE occupies cycles t+R+1 … t+R+S.
  - RESOLVE occupies cycle t+R+S+1, with `osc_rstn`=0 and `busy`=1.
  - `done`=1 and new `spins` during cycle t+R+S+2, with `busy`=0.
  - Latency from start to done is R+S+2 cycles.
- A new `start` is accepted in the same cycle `done` is high; back-to-back runs are legal.
- Sampled phase lags `osc_in` by `SYNC_STAGES` cycles. No alignment compensation is performed.

## Test plan
- R=4, S=8, all `osc_in` tied to one toggling source → `done` exactly 14 cycles after start, `spins`=0000, `osc_rstn` high for 12 cycles.
- R=4, S=8, `osc_in[1]` = ~`osc_in[0]`, `osc_in[2]` = `osc_in[0]`, `osc_in[3]` = ~`osc_in[0]` (all held static) → `spins`=1010.
- S=4 with `osc_in[1]` mismatching in exactly 2 sampled cycles → tie, `spins[1]`=0. With 3 mismatching cycles → `spins[1]`=1.
- Abort in RUN cycle 2 with `spins` previously 1010 → next cycle `busy`=0 and `osc_rstn`=0, no `done`, `spins` stays 1010. A subsequent start runs normally.
- `start` pulsed in RUN and in SAMPLE, and `run_cycles` changed mid-run → no effect; `done` still arrives at R+S+2.
- `rst` asserted mid-SAMPLE → `osc_rstn`, `busy`, `done` and `spins` go to 0 without waiting for a clock edge. After release, the block is idle and accepts `start`.
- R=0, S=0 → treated as 1/1: `done` 4 cycles after start.

Source files
------------

// File: rtl/anneal_controller.sv
// Annealing-run sequencer for a shorted-cell oscillator array: releases the array reset,
// settles for R cycles, counts phase mismatches against oscillator 0 for S cycles, resolves spins.
module anneal_controller #(
   parameter int N           = 4,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] run_cycles,
   input  logic [CNT_W-1:0] sample_cycles,
   input  logic [N-1:0]     osc_in,
   output logic             osc_rstn,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     spins
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_SAMPLE  = 2'd2,
      ST_RESOLVE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] r_q, r_d;
   logic [CNT_W-1:0] s_q, s_d;
   logic [CNT_W-1:0] mcnt_q [N];
   logic [CNT_W-1:0] mcnt_d [N];
   logic [N-1:0]     spins_q, spins_d;
   logic             done_q, done_d;
   logic             osc_rstn_q, osc_rstn_d;
   logic             busy_q, busy_d;
   logic [N-1:0]     sync_q [SYNC_STAGES];
   logic [N-1:0]     sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Per-oscillator synchronizer chain; osc_in is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= osc_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Next-state, counter and output computation for the run sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      s_d     = s_q;
      mcnt_d  = mcnt_q;
      spins_d = spins_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               r_d     = (run_cycles == '0) ? CNT_ONE : run_cycles;
               s_d     = (sample_cycles == '0) ? CNT_ONE : sample_cycles;
               cnt_d   = '0;
               for (int i = 0; i < N; i++) begin
                  mcnt_d[i] = '0;
               end
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == r_q - CNT_ONE) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               // Saturating mismatch count of each spin against the reference oscillator.
               for (int i = 1; i < N; i++) begin
                  if ((sync_s[i] ^ sync_s[0]) && (mcnt_q[i] != CNT_MAX)) begin
                     mcnt_d[i] = mcnt_q[i] + CNT_ONE;
                  end else begin
                     mcnt_d[i] = mcnt_q[i];
                  end
               end
               if (cnt_q == s_q - CNT_ONE) begin
                  cnt_d   = '0;
                  state_d = ST_RESOLVE;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
         end
         ST_RESOLVE: begin
            state_d = ST_IDLE;
            if (!abort) begin
               spins_d[0] = 1'b0;
               for (int i = 1; i < N; i++) begin
                  spins_d[i] = ({mcnt_q[i], 1'b0} > {1'b0, s_q});
               end
               done_d = 1'b1;
            end else begin
               done_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      osc_rstn_d = (state_d == ST_RUN) || (state_d == ST_SAMPLE);
      busy_d     = (state_d != ST_IDLE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         r_q        <= '0;
         s_q        <= '0;
         for (int i = 0; i < N; i++) begin
            mcnt_q[i] <= '0;
         end
         spins_q    <= '0;
         done_q     <= 1'b0;
         osc_rstn_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         s_q        <= s_d;
         mcnt_q     <= mcnt_d;
         spins_q    <= spins_d;
         done_q     <= done_d;
         osc_rstn_q <= osc_rstn_d;
         busy_q     <= busy_d;
      end
   end

   assign osc_rstn = osc_rstn_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign spins    = spins_q;

endmodule

// File: tb/tb_anneal_controller.sv
// Scoreboard bench for anneal_controller: each run pushes its expected spins/done cycle,
// a negedge monitor pops on every done pulse and compares.
module tb_anneal_controller;
   localparam int N     = 4;
   localparam int CNT_W = 16;
   localparam int LAG   = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] run_cycles;
   logic [CNT_W-1:0] sample_cycles;
   logic [N-1:0]     osc_in;
   logic             osc_rstn;
   logic             busy;
   logic             done;
   logic [N-1:0]     spins;

   anneal_controller #(.N(N), .CNT_W(CNT_W), .SYNC_STAGES(LAG)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .run_cycles(run_cycles), .sample_cycles(sample_cycles), .osc_in(osc_in),
      .osc_rstn(osc_rstn), .busy(busy), .done(done), .spins(spins)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] spins;
      int           dcyc;
      int           rlen;
   } exp_t;

   exp_t         sb[$];
   logic [N-1:0] pat [64];
   logic [N-1:0] model_spins;
   int           cyc;
   int           vec;
   int           errs;

   task automatic chk(input string nm, input longint act, input longint req);
      vec++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Spin i is 1 when more than half of the S synchronized samples disagree with oscillator 0.
   task automatic run(input int r_in, input int s_in, input int inj_k);
      int   re, se, mis, e;
      exp_t x;
      re = (r_in == 0) ? 1 : r_in;
      se = (s_in == 0) ? 1 : s_in;
      x.spins = '0;
      for (int i = 1; i < N; i++) begin
         mis = 0;
         for (int k = re + 1; k <= re + se; k++) begin
            if (pat[k-LAG][i] != pat[k-LAG][0]) mis++;
         end
         x.spins[i] = (2 * mis > se);
      end
      e      = cyc;
      x.dcyc = e + re + se + 2;
      x.rlen = re + se;
      sb.push_back(x);
      for (int k = 0; k <= re + se + 1; k++) begin
         start         = (k == 0) || (k == inj_k);
         run_cycles    = (k == 0) ? CNT_W'(r_in) : CNT_W'($urandom_range(0, 65535));
         sample_cycles = (k == 0) ? CNT_W'(s_in) : CNT_W'($urandom_range(0, 65535));
         osc_in        = pat[k];
         tick();
      end
      start = 1'b0;
   endtask

   task automatic fill_static(input logic [N-1:0] v);
      for (int k = 0; k < 64; k++) pat[k] = v;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 64; k++) pat[k] = N'($urandom);
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: pop one expectation per done pulse; flag missing or unexpected pulses.
   initial begin
      exp_t x;
      int   rlen_cnt, last_rlen;
      logic rstn_prev, busy_prev;
      rlen_cnt = 0; last_rlen = 0; rstn_prev = 1'b0; busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rlen_cnt = 0; rstn_prev = 1'b0; busy_prev = 1'b0;
         end else begin
            if (osc_rstn) rlen_cnt++;
            else if (rstn_prev) begin
               last_rlen = rlen_cnt;
               rlen_cnt  = 0;
            end
            rstn_prev = osc_rstn;
            if (done) begin
               if (sb.size() == 0) chk("unexpected_done", 1, 0);
               else begin
                  x = sb.pop_front();
                  chk("spins", spins, x.spins);
                  chk("done_cycle", cyc, x.dcyc);
                  chk("rstn_high_len", last_rlen, x.rlen);
                  chk("busy_at_done", busy, 0);
                  chk("busy_in_resolve", busy_prev, 1);
                  model_spins = x.spins;
               end
            end else if (sb.size() > 0 && cyc > sb[0].dcyc) begin
               chk("done_missing", cyc, sb[0].dcyc);
               void'(sb.pop_front());
            end
            busy_prev = busy;
         end
      end
   end

   initial begin
      int r, s, inj;
      vec = 0; errs = 0; model_spins = '0;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      run_cycles = '0; sample_cycles = '0; osc_in = '0;
      fill_static('0);
      repeat (3) tick();
      chk("rst_osc_rstn", osc_rstn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_spins", spins, 0);
      rst = 1'b0;
      tick();

      // Common toggling source: no mismatches.
      for (int k = 0; k < 64; k++) pat[k] = {N{k[0]}};
      run(4, 8, -1);
      idle(2);

      // Static inverted/equal pattern.
      fill_static(4'b1010);
      run(4, 8, -1);
      idle(2);

      // Tie and just-over-half with S=4 (window is pattern slots 3..6).
      fill_static('0);
      pat[3] = 4'b0010; pat[5] = 4'b0010;
      run(4, 4, -1);
      pat[4] = 4'b0010;
      run(4, 4, -1);
      idle(1);

      // Abort in RUN cycle 2 keeps previous spins.
      fill_static(4'b1010);
      run(4, 8, -1);
      idle(1);
      start = 1'b1; run_cycles = 16'd4; sample_cycles = 16'd8; osc_in = pat[0];
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_osc_rstn", osc_rstn, 0);
      chk("abort_spins", spins, model_spins);
      tick();
      idle(16);
      chk("abort_spins_hold", spins, model_spins);
      fill_random();
      run(3, 5, -1);
      idle(1);

      // Start pulses while busy with run_cycles/sample_cycles churning.
      fill_random();
      run(5, 6, 3);
      fill_random();
      run(3, 7, 9);
      idle(2);

      // Asynchronous reset mid-SAMPLE.
      fill_random();
      start = 1'b1; run_cycles = 16'd2; sample_cycles = 16'd8; osc_in = pat[0];
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         osc_in = pat[k];
         tick();
      end
      #1 rst = 1'b1;
      #1;
      chk("midrst_osc_rstn", osc_rstn, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_spins", spins, 0);
      tick();
      rst = 1'b0;
      model_spins = '0;
      tick();
      fill_random();
      run(0, 0, -1);
      idle(1);

      // Randomized runs, often back-to-back.
      for (int n = 0; n < 25; n++) begin
         r = $urandom_range(0, 6);
         s = $urandom_range(0, 10);
         fill_random();
         inj = ($urandom_range(0, 2) == 0) ?
               $urandom_range(1, ((r == 0) ? 1 : r) + ((s == 0) ? 1 : s) + 1) : -1;
         run(r, s, inj);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
      if (sb.size() != 0) chk("drain", sb.size(), 0);
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
